// File: rtl/game_controller_pkg.sv
// Shared types and constants for the road-crossing game controller.
// Holds the state encoding, the display range, the grid geometry and the car step period rule.
package game_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_LEVEL = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int LEVEL_RANGE  = 99;
  localparam int GRID_COLS    = 20;
  localparam int GRID_ROWS    = 15;
  localparam int ROW_W        = 4;
  localparam int FLASH_FRAMES = 8;

  // Every four levels shortens the period by one frame, down to a floor.
  function automatic logic [5:0] step_period(input logic [6:0] level, input int base,
                                             input int floor_p);
    logic [6:0] shifted;
    shifted = level >> 2;
    if (shifted >= 7'(base - floor_p)) return 6'(floor_p);
    return 6'(7'(base) - shifted);
  endfunction

endpackage

// File: rtl/game_controller_frame_divider.sv
// Counts qualified frame ticks and flags the tick that completes a programmable period.
// Down-counter reloaded on clear and on terminal count.
module frame_divider #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] period,
  output logic         last
);

  logic [W-1:0] count;

  assign last = tick && (count == '0) && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || last) begin
      count <= period - 1'b1;
    end else if (tick) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game sequencer: play/hit/level/over flow, level and lives counters, car scheduling.
// Decisions are taken on the frame tick cycle; all outputs are registered.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int MAX_LEVEL    = LEVEL_RANGE,
  parameter int GOAL_ROW     = 1,
  parameter int BASE_PERIOD  = 30,
  parameter int MIN_PERIOD   = 4,
  parameter int HIT_FRAMES   = 60,
  parameter int LEVEL_FRAMES = 30
) (
  input  logic       i_Clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_start,
  input  logic [3:0] i_player_y,
  input  logic       i_collision,
  output logic [2:0] o_state,
  output logic [6:0] o_level,
  output logic [1:0] o_lives,
  output logic       o_player_reset,
  output logic       o_cars_enable,
  output logic       o_car_step,
  output logic [5:0] o_car_period,
  output logic       o_flash,
  output logic       o_game_over
);

  state_t     state;
  logic       start_q;
  logic       start_rise;
  logic       coll_latch;
  logic       entry;
  logic       goal;
  logic       step_tick;
  logic       hold_tick;
  logic       flash_tick;
  logic       step_last;
  logic       hold_last;
  logic       flash_last;
  logic [6:0] hold_period;

  assign o_state     = state;
  assign start_rise  = i_start && !start_q;
  assign goal        = (i_player_y == ROW_W'(GOAL_ROW));
  // The exit frame neither advances the step count nor issues a step.
  assign step_tick   = i_frame_tick && (state == S_PLAY) && !coll_latch && !goal;
  assign hold_tick   = i_frame_tick && ((state == S_HIT) || (state == S_LEVEL));
  assign flash_tick  = i_frame_tick && (state == S_HIT);
  assign hold_period = (state == S_HIT) ? 7'(HIT_FRAMES) : 7'(LEVEL_FRAMES);

  frame_divider #(.W(6)) u_step (
    .clk(i_Clk), .rst(i_reset), .clear(entry), .tick(step_tick),
    .period(o_car_period), .last(step_last)
  );

  frame_divider #(.W(7)) u_hold (
    .clk(i_Clk), .rst(i_reset), .clear(entry), .tick(hold_tick),
    .period(hold_period), .last(hold_last)
  );

  frame_divider #(.W(4)) u_flash (
    .clk(i_Clk), .rst(i_reset), .clear(entry), .tick(flash_tick),
    .period(4'(FLASH_FRAMES)), .last(flash_last)
  );

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_IDLE;
      start_q        <= 1'b0;
      coll_latch     <= 1'b0;
      entry          <= 1'b0;
      o_level        <= 7'd0;
      o_lives        <= 2'(LIVES);
      o_player_reset <= 1'b0;
      o_cars_enable  <= 1'b0;
      o_car_step     <= 1'b0;
      o_car_period   <= 6'(BASE_PERIOD);
      o_flash        <= 1'b0;
      o_game_over    <= 1'b0;
    end else begin
      start_q        <= i_start;
      entry          <= 1'b0;
      o_player_reset <= 1'b0;
      o_car_step     <= step_last;
      o_car_period   <= step_period(o_level, BASE_PERIOD, MIN_PERIOD);
      if (i_frame_tick) coll_latch <= 1'b0;
      else if (i_collision) coll_latch <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_rise) begin
            state          <= S_PLAY;
            entry          <= 1'b1;
            o_player_reset <= 1'b1;
            o_cars_enable  <= 1'b1;
            coll_latch     <= 1'b0;
          end
        end
        S_PLAY: begin
          if (i_frame_tick) begin
            if (coll_latch) begin
              state         <= S_HIT;
              entry         <= 1'b1;
              o_cars_enable <= 1'b0;
              o_flash       <= 1'b1;
              if (o_lives != 2'd0) o_lives <= o_lives - 2'd1;
            end else if (goal) begin
              state         <= S_LEVEL;
              entry         <= 1'b1;
              o_cars_enable <= 1'b0;
              o_level       <= (o_level == 7'(MAX_LEVEL)) ? 7'd0 : o_level + 7'd1;
            end
          end
        end
        S_HIT: begin
          if (hold_last) begin
            entry   <= 1'b1;
            o_flash <= 1'b0;
            if (o_lives == 2'd0) begin
              state       <= S_OVER;
              o_game_over <= 1'b1;
            end else begin
              state          <= S_PLAY;
              o_player_reset <= 1'b1;
              o_cars_enable  <= 1'b1;
            end
          end else if (flash_last) begin
            o_flash <= ~o_flash;
          end
        end
        S_LEVEL: begin
          if (hold_last) begin
            state          <= S_PLAY;
            entry          <= 1'b1;
            o_player_reset <= 1'b1;
            o_cars_enable  <= 1'b1;
          end
        end
        S_OVER: begin
          if (start_rise) begin
            state       <= S_IDLE;
            entry       <= 1'b1;
            o_game_over <= 1'b0;
            o_level     <= 7'd0;
            o_lives     <= 2'(LIVES);
            coll_latch  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed steps plus random frames checked against a frame-level model.
// A second instance with a short base period exercises the period floor.
module tb_game_controller;

  localparam int BASE2 = 10;
  localparam int MIN2  = 4;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_frame_tick = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] i_player_y = 4'd5;
  logic       i_collision = 1'b0;

  logic [2:0] st, st2;
  logic [6:0] lvl, lvl2;
  logic [1:0] lv, lv2;
  logic       pr, pr2, ce, ce2, cs, cs2, fl, fl2, go, go2;
  logic [5:0] cp, cp2;

  int total = 0;
  int bad = 0;
  int n_steps = 0;

  int m_state, m_level, m_lives, m_play, m_hold;
  bit e_reset, e_step, e_step2;

  always #20 clk = ~clk;

  game_controller dut (
    .i_Clk(clk), .i_reset(i_reset), .i_frame_tick(i_frame_tick), .i_start(i_start),
    .i_player_y(i_player_y), .i_collision(i_collision),
    .o_state(st), .o_level(lvl), .o_lives(lv), .o_player_reset(pr), .o_cars_enable(ce),
    .o_car_step(cs), .o_car_period(cp), .o_flash(fl), .o_game_over(go)
  );

  game_controller #(.BASE_PERIOD(BASE2), .MIN_PERIOD(MIN2)) dut2 (
    .i_Clk(clk), .i_reset(i_reset), .i_frame_tick(i_frame_tick), .i_start(i_start),
    .i_player_y(i_player_y), .i_collision(i_collision),
    .o_state(st2), .o_level(lvl2), .o_lives(lv2), .o_player_reset(pr2), .o_cars_enable(ce2),
    .o_car_step(cs2), .o_car_period(cp2), .o_flash(fl2), .o_game_over(go2)
  );

  function automatic int mper(input int level, input int base, input int mn);
    int s;
    s = level / 4;
    return (s >= base - mn) ? mn : base - s;
  endfunction

  function automatic int ry();
    return int'($urandom_range(2, 14));
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic check_outs();
    bit ef;
    ef = (m_state == 2) && (((m_hold / 8) % 2) == 0);
    chk("state", 32'(st), 32'(m_state));
    chk("level", 32'(lvl), 32'(m_level));
    chk("lives", 32'(lv), 32'(m_lives));
    chk("player_reset", 32'(pr), 32'(e_reset));
    chk("cars_enable", 32'(ce), 32'(m_state == 1));
    chk("car_step", 32'(cs), 32'(e_step));
    chk("flash", 32'(fl), 32'(ef));
    chk("game_over", 32'(go), 32'(m_state == 4));
    chk("d2_state", 32'(st2), 32'(m_state));
    chk("d2_level", 32'(lvl2), 32'(m_level));
    chk("d2_lives", 32'(lv2), 32'(m_lives));
    chk("d2_player_reset", 32'(pr2), 32'(e_reset));
    chk("d2_cars_enable", 32'(ce2), 32'(m_state == 1));
    chk("d2_car_step", 32'(cs2), 32'(e_step2));
    chk("d2_flash", 32'(fl2), 32'(ef));
    chk("d2_game_over", 32'(go2), 32'(m_state == 4));
  endtask

  task automatic check_period();
    chk("car_period", 32'(cp), 32'(mper(m_level, 30, 4)));
    chk("d2_car_period", 32'(cp2), 32'(mper(m_level, BASE2, MIN2)));
  endtask

  task automatic model_reset();
    m_state = 0; m_level = 0; m_lives = 3; m_play = 0; m_hold = 0;
    e_reset = 0; e_step = 0; e_step2 = 0;
  endtask

  // One frame: optional collision and start early, player row held, then the tick.
  task automatic frame(input bit c, input int y, input bit s);
    @(negedge clk);
    i_player_y = 4'(y); i_collision = c; i_start = s;
    check_period();
    @(negedge clk);
    i_collision = 1'b0;
    @(negedge clk);
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0; i_start = 1'b0;
    e_reset = 0; e_step = 0; e_step2 = 0;
    case (m_state)
      1: begin
        if (c) begin
          m_state = 2; m_hold = 0;
          if (m_lives > 0) m_lives--;
        end else if (y == 1) begin
          m_state = 3; m_hold = 0;
          m_level = (m_level == 99) ? 0 : m_level + 1;
        end else begin
          m_play++;
          e_step  = (m_play % mper(m_level, 30, 4)) == 0;
          e_step2 = (m_play % mper(m_level, BASE2, MIN2)) == 0;
        end
      end
      2: begin
        m_hold++;
        if (m_hold == 60) begin
          if (m_lives == 0) m_state = 4;
          else begin m_state = 1; m_play = 0; e_reset = 1; end
        end
      end
      3: begin
        m_hold++;
        if (m_hold == 30) begin m_state = 1; m_play = 0; e_reset = 1; end
      end
      default: ;
    endcase
    if (cs) n_steps++;
    check_outs();
    @(negedge clk);
    e_reset = 0; e_step = 0; e_step2 = 0;
    if (cs) n_steps++;
    check_outs();
  endtask

  task automatic press_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    e_reset = 0; e_step = 0; e_step2 = 0;
    if (m_state == 0) begin
      m_state = 1; m_play = 0; e_reset = 1;
    end else if (m_state == 4) begin
      m_state = 0; m_level = 0; m_lives = 3;
    end
    check_outs();
    i_start = 1'b0;
    @(negedge clk);
    e_reset = 0;
    check_outs();
  endtask

  initial begin
    bit seen99;
    bit wrapped;
    model_reset();
    repeat (3) @(negedge clk);
    check_outs();
    check_period();
    i_reset = 1'b0;
    @(negedge clk);
    check_outs();

    press_start();
    n_steps = 0;
    for (int i = 0; i < 60; i++) frame(1'b0, ry(), 1'b0);
    chk("steps_in_60", 32'(n_steps), 32'd2);

    frame(1'b0, 1, 1'b0);
    for (int i = 0; i < 30; i++) frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 14)), 1'b0);

    frame(1'b1, 1, 1'b0);
    for (int i = 0; i < 20; i++)
      frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));

    @(negedge clk);
    i_reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    check_period();
    @(negedge clk);
    i_reset = 1'b0;

    press_start();
    for (int i = 0; i < 300; i++) begin
      if (m_state == 0 || m_state == 4) press_start();
      else frame(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0) ? 1 : ry(),
                 ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 400 && m_state != 4; i++) begin
      if (m_state == 0) press_start();
      else frame(m_state == 1, 5, 1'b0);
    end
    chk("game_over_reached", 32'(go), 32'd1);
    press_start();
    press_start();

    seen99 = 0;
    wrapped = 0;
    for (int i = 0; i < 4000 && !(wrapped && m_state == 1); i++) begin
      if (m_state == 1) frame(1'b0, 1, 1'b0);
      else frame(1'($urandom_range(0, 1)), ry(), 1'b0);
      if (m_level == 99) seen99 = 1;
      if (seen99 && m_level == 0) wrapped = 1;
    end
    frame(1'b0, ry(), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
